// File: rtl/mem_access_stage_if.sv
// Signal bundle of the MEM stage: EX inputs, data-memory port and MEM results.
// The stage drives through the master modport; the pipeline/memory environment uses slave.
interface mem_access_stage_if #(
  parameter int DATA_W = 32
);
  logic              EX_valid;
  logic [6:0]        EX_opcode;
  logic [DATA_W-1:0] EX_alu_result;
  logic [DATA_W-1:0] EX_r2;
  logic [4:0]        EX_rd;
  logic              EX_regwrite;
  logic              mem_stall;

  // dmem handshake: dmem_req rises when an access starts and stays high, with dmem_addr,
  // dmem_we and dmem_wdata stable, up to and including the first cycle dmem_ack is high;
  // that cycle completes the access (dmem_rdata valid for loads). Ack without req is ignored.
  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_ack;
  logic [DATA_W-1:0] dmem_rdata;

  logic              MEM_valid;
  logic [DATA_W-1:0] MEM_data;
  logic [4:0]        MEM_rd;
  logic              MEM_regwrite;
  logic              bus_err;

  modport master (
    input  EX_valid, EX_opcode, EX_alu_result, EX_r2, EX_rd, EX_regwrite,
    input  dmem_ack, dmem_rdata,
    output mem_stall, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output MEM_valid, MEM_data, MEM_rd, MEM_regwrite, bus_err
  );

  modport slave (
    output EX_valid, EX_opcode, EX_alu_result, EX_r2, EX_rd, EX_regwrite,
    output dmem_ack, dmem_rdata,
    input  mem_stall, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  MEM_valid, MEM_data, MEM_rd, MEM_regwrite, bus_err
  );
endinterface

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: registers ALU results, runs LW/SW over the req/ack dmem port with timeout.
// Optional macro MEM_ALIGN_CHECK_EN: misaligned LW/SW are not issued and retire with bus_err.
module mem_access_stage #(
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic               clk,
  input  logic               reset,
  mem_access_stage_if.master bus,
  output logic               o_dbg_state
);
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACCESS = 1'b1;
  localparam int         CW       = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  logic [0:0]        r_state;
  logic [CW-1:0]     r_cnt;
  logic [DATA_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_we;
  logic [4:0]        r_rd;
  logic              r_mem_valid;
  logic [DATA_W-1:0] r_mem_data;
  logic [4:0]        r_mem_rd;
  logic              r_mem_regwrite;
  logic              r_bus_err;

  logic w_mem_op;
  logic w_misalign;
  logic w_issue;
  logic w_cnt_last;

  assign w_mem_op = bus.EX_valid & ((bus.EX_opcode == OP_LW) | (bus.EX_opcode == OP_SW));

`ifdef MEM_ALIGN_CHECK_EN
  assign w_misalign = (bus.EX_alu_result[1:0] != 2'b00);
`else
  assign w_misalign = 1'b0;
`endif

  assign w_issue    = w_mem_op & ~w_misalign;
  assign w_cnt_last = (r_cnt == CNT_LAST);

  // In ACCESS the upstream advances on the ack edge, and also on the timeout edge.
  assign bus.mem_stall = (r_state == S_IDLE) ? w_issue : ~(bus.dmem_ack | w_cnt_last);
  assign bus.dmem_req  = (r_state == S_ACCESS);
  assign bus.dmem_we   = r_we;
  assign bus.dmem_addr = r_addr;
  assign bus.dmem_wdata = r_wdata;

  assign bus.MEM_valid    = r_mem_valid;
  assign bus.MEM_data     = r_mem_data;
  assign bus.MEM_rd       = r_mem_rd;
  assign bus.MEM_regwrite = r_mem_regwrite;
  assign bus.bus_err      = r_bus_err;
  assign o_dbg_state      = r_state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_addr         <= '0;
      r_wdata        <= '0;
      r_we           <= 1'b0;
      r_rd           <= '0;
      r_mem_valid    <= 1'b0;
      r_mem_data     <= '0;
      r_mem_rd       <= '0;
      r_mem_regwrite <= 1'b0;
      r_bus_err      <= 1'b0;
    end else begin
      r_bus_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_issue) begin
            r_state        <= S_ACCESS;
            r_addr         <= bus.EX_alu_result;
            r_wdata        <= bus.EX_r2;
            r_we           <= (bus.EX_opcode == OP_SW);
            r_rd           <= bus.EX_rd;
            r_mem_valid    <= 1'b0;
            r_mem_regwrite <= 1'b0;
          end else if (w_mem_op) begin
            // Rejected misaligned access retires immediately without side effects.
            r_mem_valid    <= 1'b1;
            r_mem_rd       <= bus.EX_rd;
            r_mem_regwrite <= 1'b0;
            r_bus_err      <= 1'b1;
          end else begin
            r_mem_valid    <= bus.EX_valid;
            r_mem_data     <= bus.EX_alu_result;
            r_mem_rd       <= bus.EX_rd;
            r_mem_regwrite <= bus.EX_valid & bus.EX_regwrite & (bus.EX_rd != 5'd0);
          end
        end
        S_ACCESS: begin
          if (bus.dmem_ack) begin
            r_state     <= S_IDLE;
            r_mem_valid <= 1'b1;
            r_mem_rd    <= r_rd;
            if (!r_we) begin
              r_mem_data     <= bus.dmem_rdata;
              r_mem_regwrite <= (r_rd != 5'd0);
            end else begin
              r_mem_regwrite <= 1'b0;
            end
          end else if (w_cnt_last) begin
            r_state        <= S_IDLE;
            r_mem_valid    <= 1'b1;
            r_mem_rd       <= r_rd;
            r_mem_regwrite <= 1'b0;
            r_bus_err      <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: pass-through vector table, directed memory
// sequences (latency, timeout, reset mid-access) and randomized instruction streams.
`timescale 1ns/1ps
module tb_mem_access_stage;
  localparam int DW = 32;
  localparam int TO = 16;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_ADD  = 7'b0110011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic dbg_state;

  mem_access_stage_if #(.DATA_W(DW)) bus();

  mem_access_stage #(.DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic          bus_err;
    logic          rw;
    logic          chk_data;
    logic [4:0]    rd;
    logic [DW-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] model_mem [logic [DW-1:0]];
  logic [DW-1:0] dev_mem   [logic [DW-1:0]];

  function automatic logic [DW-1:0] init_word(input logic [DW-1:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    if (bus.MEM_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_retire: got MEM_valid=1 expected no retire");
      end else begin
        e = exp_q.pop_front();
        check("retire_bus_err", bus.bus_err, e.bus_err);
        check("retire_regwrite", bus.MEM_regwrite, e.rw);
        if (!e.bus_err) check("retire_rd", bus.MEM_rd, e.rd);
        if (e.chk_data) check("retire_data", bus.MEM_data, e.data);
      end
    end else begin
      check("bus_err_without_valid", bus.bus_err, 1'b0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    monitor();
  endtask

  // ---------------- driver tasks ----------------
  task automatic bubble();
    bus.EX_valid      = 1'b0;
    bus.EX_opcode     = ($urandom_range(0, 1) == 0) ? OP_LW : OP_ADD;
    bus.EX_alu_result = $urandom;
    bus.EX_rd         = 5'($urandom_range(0, 31));
    bus.dmem_ack      = 1'($urandom_range(0, 1));
    bus.dmem_rdata    = $urandom;
    #1;
    check("bubble_stall", bus.mem_stall, 1'b0);
    tick();
    bus.dmem_ack = 1'b0;
  endtask

  // Drives one instruction until it leaves EX, acting as the data memory; ack_wait is the
  // number of no-ack ACCESS cycles before ack (>= TO means never ack).
  task automatic run_instr(input logic [6:0] op, input logic [DW-1:0] alu, input logic [DW-1:0] r2,
                           input logic [4:0] rd, input logic rw, input int ack_wait);
    exp_t e;
    logic is_mem, misal, done, cap_we;
    logic [DW-1:0] cap_addr, cap_wdata;
    int req_cnt, stall_cnt, n, exp_stall, exp_req;
    is_mem = (op == OP_LW) || (op == OP_SW);
    misal  = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    misal = is_mem && (alu[1:0] != 2'b00);
`endif
    e = '0;
    e.rd = rd;
    if (!is_mem) begin
      e.rw = rw && (rd != 5'd0);
      e.data = alu;
      e.chk_data = 1'b1;
      exp_stall = 0;
      exp_req = 0;
    end else if (misal) begin
      e.bus_err = 1'b1;
      exp_stall = 0;
      exp_req = 0;
    end else if (ack_wait >= TO) begin
      e.bus_err = 1'b1;
      exp_stall = TO;
      exp_req = TO;
    end else begin
      exp_stall = 1 + ack_wait;
      exp_req = ack_wait + 1;
      if (op == OP_LW) begin
        e.rw = (rd != 5'd0);
        e.data = model_mem.exists(alu) ? model_mem[alu] : init_word(alu);
        e.chk_data = 1'b1;
      end else begin
        model_mem[alu] = r2;
      end
    end
    exp_q.push_back(e);

    bus.EX_valid = 1'b1;
    bus.EX_opcode = op;
    bus.EX_alu_result = alu;
    bus.EX_r2 = r2;
    bus.EX_rd = rd;
    bus.EX_regwrite = rw;
    done = 1'b0;
    req_cnt = 0;
    stall_cnt = 0;
    n = 0;
    cap_addr = '0;
    cap_wdata = '0;
    cap_we = 1'b0;
    while (!done && n < 64) begin
      bus.dmem_ack = 1'b0;
      bus.dmem_rdata = $urandom;
      if (bus.dmem_req === 1'b1) begin
        if (req_cnt == 0) begin
          cap_addr = bus.dmem_addr;
          cap_wdata = bus.dmem_wdata;
          cap_we = bus.dmem_we;
          check("dmem_addr", bus.dmem_addr, alu);
          check("dmem_we", bus.dmem_we, (op == OP_SW));
          if (op == OP_SW) check("dmem_wdata", bus.dmem_wdata, r2);
        end else begin
          check("addr_stable", bus.dmem_addr, cap_addr);
          check("wdata_stable", bus.dmem_wdata, cap_wdata);
          check("we_stable", bus.dmem_we, cap_we);
        end
        if (req_cnt == ack_wait) begin
          bus.dmem_ack = 1'b1;
          if (bus.dmem_we) dev_mem[bus.dmem_addr] = bus.dmem_wdata;
          else bus.dmem_rdata = dev_mem.exists(bus.dmem_addr) ? dev_mem[bus.dmem_addr]
                                                              : init_word(bus.dmem_addr);
        end
        req_cnt++;
      end else begin
        bus.dmem_ack = ($urandom_range(0, 3) == 0);
      end
      #1;
      if (bus.mem_stall === 1'b1) stall_cnt++;
      else done = 1'b1;
      tick();
      n++;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL stall_bound: got stall for %0d cycles expected release", n);
    end
    check("stall_cycles", stall_cnt, exp_stall);
    check("req_cycles", req_cnt, exp_req);
    check("retire_latency", exp_q.size(), 0);
    bus.EX_valid = 1'b0;
    bus.dmem_ack = 1'b0;
  endtask

  // ---------------- pass-through vector table ----------------
  typedef struct {
    logic          valid;
    logic [6:0]    op;
    logic [DW-1:0] alu;
    logic [4:0]    rd;
    logic          rw;
    logic          exp_valid;
    logic [DW-1:0] exp_data;
    logic          exp_rw;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{1'b1, OP_ADD,  32'h0000_0007,  5'd5, 1'b1, 1'b1, 32'h0000_0007, 1'b1};
    vecs[1] = '{1'b1, OP_ADD,  32'hFFFF_FFFF, 5'd31, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1};
    vecs[2] = '{1'b1, OP_ADD,  32'h0000_1234,  5'd0, 1'b1, 1'b1, 32'h0000_1234, 1'b0};
    vecs[3] = '{1'b1, OP_ADD,  32'h0000_ABCD,  5'd9, 1'b0, 1'b1, 32'h0000_ABCD, 1'b0};
    vecs[4] = '{1'b0, OP_ADD,  32'h0000_0055,  5'd4, 1'b1, 1'b0, 32'h0000_0055, 1'b0};
    vecs[5] = '{1'b0, OP_LW,   32'h0000_0100,  5'd6, 1'b1, 1'b0, 32'h0000_0100, 1'b0};
    vecs[6] = '{1'b1, OP_ADDI, 32'h8000_0000,  5'd1, 1'b1, 1'b1, 32'h8000_0000, 1'b1};

    bus.EX_valid = 1'b0;
    bus.EX_opcode = OP_ADD;
    bus.EX_alu_result = '0;
    bus.EX_r2 = '0;
    bus.EX_rd = '0;
    bus.EX_regwrite = 1'b0;
    bus.dmem_ack = 1'b0;
    bus.dmem_rdata = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", bus.dmem_req, 1'b0);
    check("rst_valid", bus.MEM_valid, 1'b0);
    check("rst_data", bus.MEM_data, '0);
    check("rst_regwrite", bus.MEM_regwrite, 1'b0);
    check("rst_bus_err", bus.bus_err, 1'b0);
    check("rst_state", dbg_state, 1'b0);
    reset = 1'b0;
    tick();

    // Pass-through table
    for (int i = 0; i < 7; i++) begin
      bus.EX_valid = vecs[i].valid;
      bus.EX_opcode = vecs[i].op;
      bus.EX_alu_result = vecs[i].alu;
      bus.EX_rd = vecs[i].rd;
      bus.EX_regwrite = vecs[i].rw;
      #1;
      check("pt_stall", bus.mem_stall, 1'b0);
      @(posedge clk);
      #1;
      check("pt_valid", bus.MEM_valid, vecs[i].exp_valid);
      check("pt_data", bus.MEM_data, vecs[i].exp_data);
      check("pt_rd", bus.MEM_rd, vecs[i].rd);
      check("pt_regwrite", bus.MEM_regwrite, vecs[i].exp_rw);
    end
    bus.EX_valid = 1'b0;
    tick();

    // Directed memory sequences
    model_mem[32'h100] = 32'hDEAD_BEEF;
    dev_mem[32'h100]   = 32'hDEAD_BEEF;
    run_instr(OP_LW, 32'h100, 32'h0, 5'd3, 1'b1, 0);
    run_instr(OP_SW, 32'h104, 32'h55, 5'd0, 1'b0, 3);
    run_instr(OP_LW, 32'h104, 32'h0, 5'd8, 1'b1, 1);
    run_instr(OP_LW, 32'h108, 32'h0, 5'd2, 1'b1, TO);
    check("state_after_timeout", dbg_state, 1'b0);
    run_instr(OP_LW, 32'h108, 32'h0, 5'd2, 1'b1, TO - 1);
    run_instr(OP_LW, 32'h100, 32'h0, 5'd0, 1'b1, 0);
    run_instr(OP_SW, 32'h10C, 32'h1234_5678, 5'd4, 1'b1, TO);
    run_instr(OP_LW, 32'h10C, 32'h0, 5'd4, 1'b1, 2);
`ifdef MEM_ALIGN_CHECK_EN
    run_instr(OP_LW, 32'h102, 32'h0, 5'd5, 1'b1, 0);
`endif

    // Reset while in ACCESS
    bus.EX_valid = 1'b1;
    bus.EX_opcode = OP_LW;
    bus.EX_alu_result = 32'h200;
    bus.EX_rd = 5'd7;
    bus.EX_regwrite = 1'b1;
    tick();
    bus.EX_valid = 1'b0;
    tick();
    check("pre_reset_req", bus.dmem_req, 1'b1);
    reset = 1'b1;
    #1;
    check("mid_rst_req", bus.dmem_req, 1'b0);
    check("mid_rst_valid", bus.MEM_valid, 1'b0);
    check("mid_rst_data", bus.MEM_data, '0);
    check("mid_rst_rd", bus.MEM_rd, '0);
    check("mid_rst_regwrite", bus.MEM_regwrite, 1'b0);
    check("mid_rst_state", dbg_state, 1'b0);
    tick();
    reset = 1'b0;
    tick();
    tick();
    run_instr(OP_ADD, 32'h0000_0007, 32'h0, 5'd5, 1'b1, 0);

    // Randomized instruction stream
    for (int i = 0; i < 80; i++) begin
      int r, w;
      logic [6:0] op;
      logic [DW-1:0] addr;
      r = $urandom_range(0, 9);
      if (r < 2) begin
        bubble();
      end else begin
        op = (r < 4) ? OP_ADD : ((r < 7) ? OP_LW : OP_SW);
        addr = 32'h100 + 32'($urandom_range(0, 7) * 4);
        if ($urandom_range(0, 7) == 0) addr = addr + 32'($urandom_range(1, 3));
        if (op == OP_ADD) addr = $urandom;
        w = $urandom_range(0, 3);
        if ($urandom_range(0, 9) == 0) w = TO - 1 + $urandom_range(0, 3);
        run_instr(op, addr, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), w);
      end
    end
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
